// File: rtl/mem_bus_pkg.sv
// Shared AXI-lite bus types, response codes and arbiter state/owner encodings.
// ERR_RSP state exists only when ARB_TIMEOUT_EN is defined.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic              rready;
    logic              awvalid;
    logic [ADDR_W-1:0] awaddr;
    logic              wvalid;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              bready;
  } axi_req_t;

  typedef struct packed {
    logic              arready;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              awready;
    logic              wready;
    logic              bvalid;
    logic [1:0]        bresp;
  } axi_rsp_t;

  typedef enum logic [2:0] {
    IDLE,
    IFU_RD,
    LSU_RD,
    LSU_WR
`ifdef ARB_TIMEOUT_EN
    ,
    ERR_RSP
`endif
  } arb_state_e;

  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_IFU_RD = 2'b01;
  localparam logic [1:0] OWN_LSU_RD = 2'b10;
  localparam logic [1:0] OWN_LSU_WR = 2'b11;

endpackage

// File: rtl/mem_arbiter.sv
// Grants the shared SRAM to IFU or LSU for one whole AXI-lite transaction; 1-cycle arbitration.
// Optional grant watchdog with DECERR response when ARB_TIMEOUT_EN is defined.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  axi_req_t   ifu_req,
  output axi_rsp_t   ifu_rsp,
  input  axi_req_t   lsu_req,
  output axi_rsp_t   lsu_rsp,
  output axi_req_t   mem_req,
  input  axi_rsp_t   mem_rsp,
  output logic [1:0] owner,
  output logic       busy
);

  arb_state_e state_q;
  arb_state_e state_nxt;
  logic       unused_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       err_owner_q;
  logic             timeout;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // err_owner_q freezes on entry to ERR_RSP so the error goes to the master that held the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      err_owner_q <= OWN_NONE;
    end else begin
      if (state_q == IDLE) begin
        cnt_q <= '0;
      end else if (state_q != ERR_RSP) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (state_q != ERR_RSP) begin
        err_owner_q <= owner;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state_q;
    mem_req   = '0;
    ifu_rsp   = '0;
    lsu_rsp   = '0;
    owner     = OWN_NONE;
    case (state_q)
      IDLE: begin
        if (lsu_req.awvalid || lsu_req.wvalid) begin
          state_nxt = LSU_WR;
        end else if (lsu_req.arvalid) begin
          state_nxt = LSU_RD;
        end else if (ifu_req.arvalid) begin
          state_nxt = IFU_RD;
        end
      end
      IFU_RD: begin
        owner           = OWN_IFU_RD;
        mem_req.arvalid = ifu_req.arvalid;
        mem_req.araddr  = ifu_req.araddr;
        mem_req.rready  = ifu_req.rready;
        ifu_rsp.arready = mem_rsp.arready;
        ifu_rsp.rvalid  = mem_rsp.rvalid;
        ifu_rsp.rdata   = mem_rsp.rdata;
        ifu_rsp.rresp   = mem_rsp.rresp;
        if (mem_rsp.rvalid && ifu_req.rready) begin
          state_nxt = IDLE;
        end
      end
      LSU_RD: begin
        owner           = OWN_LSU_RD;
        mem_req.arvalid = lsu_req.arvalid;
        mem_req.araddr  = lsu_req.araddr;
        mem_req.rready  = lsu_req.rready;
        lsu_rsp.arready = mem_rsp.arready;
        lsu_rsp.rvalid  = mem_rsp.rvalid;
        lsu_rsp.rdata   = mem_rsp.rdata;
        lsu_rsp.rresp   = mem_rsp.rresp;
        if (mem_rsp.rvalid && lsu_req.rready) begin
          state_nxt = IDLE;
        end
      end
      LSU_WR: begin
        owner           = OWN_LSU_WR;
        mem_req.awvalid = lsu_req.awvalid;
        mem_req.awaddr  = lsu_req.awaddr;
        mem_req.wvalid  = lsu_req.wvalid;
        mem_req.wdata   = lsu_req.wdata;
        mem_req.wstrb   = lsu_req.wstrb;
        mem_req.bready  = lsu_req.bready;
        lsu_rsp.awready = mem_rsp.awready;
        lsu_rsp.wready  = mem_rsp.wready;
        lsu_rsp.bvalid  = mem_rsp.bvalid;
        lsu_rsp.bresp   = mem_rsp.bresp;
        if (mem_rsp.bvalid && lsu_req.bready) begin
          state_nxt = IDLE;
        end
      end
`ifdef ARB_TIMEOUT_EN
      ERR_RSP: begin
        owner = err_owner_q;
        case (err_owner_q)
          OWN_LSU_WR: begin
            lsu_rsp.bvalid = 1'b1;
            lsu_rsp.bresp  = RESP_DECERR;
            if (lsu_req.bready) state_nxt = IDLE;
          end
          OWN_LSU_RD: begin
            lsu_rsp.rvalid = 1'b1;
            lsu_rsp.rresp  = RESP_DECERR;
            if (lsu_req.rready) state_nxt = IDLE;
          end
          default: begin
            ifu_rsp.rvalid = 1'b1;
            ifu_rsp.rresp  = RESP_DECERR;
            if (ifu_req.rready) state_nxt = IDLE;
          end
        endcase
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
`ifdef ARB_TIMEOUT_EN
    // A completion in the final allowed cycle wins over the watchdog.
    if (owner != OWN_NONE && state_q != ERR_RSP && state_nxt == state_q && timeout) begin
      state_nxt = ERR_RSP;
    end
`endif
  end

  assign busy = (state_q != IDLE);

  // IFU write-channel fields are never forwarded.
  assign unused_ok = ^{ifu_req.awvalid, ifu_req.awaddr, ifu_req.wvalid, ifu_req.wdata,
                       ifu_req.wstrb, ifu_req.bready, (TIMEOUT_CYCLES > 0)};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a behavioural SRAM slave and per-master scoreboards.
module tb_mem_arbiter;
  import mem_bus_pkg::*;

  localparam int TO     = 16;
  localparam int BUDGET = 64;

  logic       clk = 1'b0;
  logic       rst;
  axi_req_t   ifu_req, lsu_req, mem_req;
  axi_rsp_t   ifu_rsp, lsu_rsp, mem_rsp;
  logic [1:0] owner;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_rsp(ifu_rsp),
    .lsu_req(lsu_req), .lsu_rsp(lsu_rsp),
    .mem_req(mem_req), .mem_rsp(mem_rsp),
    .owner(owner), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  s;
  } wr_t;

  wr_t         wr_q[$];
  logic [31:0] ifu_q[$];
  logic [31:0] lsu_q[$];

  // Behavioural SRAM slave
  logic        hold_r;
  logic        rv_q, aw_got, w_got, bv_q;
  logic [31:0] rd_q, aw_a, w_d;
  logic [7:0]  w_s;
  logic [31:0] sram [logic [31:0]];

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'h0000_0413 : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [7:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    mem_rsp         = '0;
    mem_rsp.arready = !rv_q;
    mem_rsp.rvalid  = rv_q;
    mem_rsp.rdata   = rd_q;
    mem_rsp.rresp   = RESP_OKAY;
    mem_rsp.awready = !aw_got;
    mem_rsp.wready  = !w_got;
    mem_rsp.bvalid  = bv_q;
    mem_rsp.bresp   = RESP_OKAY;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_q <= 1'b0; rd_q <= '0; aw_got <= 1'b0; w_got <= 1'b0; bv_q <= 1'b0;
      aw_a <= '0; w_d <= '0; w_s <= '0;
    end else begin
      if (mem_req.arvalid && mem_rsp.arready && !hold_r) begin
        rv_q <= 1'b1;
        rd_q <= sram.exists(mem_req.araddr) ? sram[mem_req.araddr] : init_val(mem_req.araddr);
      end else if (rv_q && mem_req.rready) begin
        rv_q <= 1'b0;
      end
      if (mem_req.awvalid && !aw_got) begin aw_got <= 1'b1; aw_a <= mem_req.awaddr; end
      if (mem_req.wvalid && !w_got) begin w_got <= 1'b1; w_d <= mem_req.wdata; w_s <= mem_req.wstrb; end
      if (aw_got && w_got && !bv_q) begin
        wr_t e;
        bv_q <= 1'b1;
        sram[aw_a] = merge(sram.exists(aw_a) ? sram[aw_a] : init_val(aw_a), w_d, w_s);
        chk("sram_write_expected", wr_q.size() != 0, 1'b1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("sram_awaddr", aw_a, e.a);
          chk("sram_wdata", w_d, e.d);
          chk("sram_wstrb", w_s, e.s);
        end
      end
      if (bv_q && mem_req.bready) begin
        bv_q <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
      end
    end
  end

  // Bus-wide invariants and grant log
  logic [1:0] prev_owner = OWN_NONE;
  logic [1:0] grant_log[$];

  always @(negedge clk) begin
    if (rst) begin
      prev_owner = OWN_NONE;
    end else begin
      chk("busy_vs_owner", busy, owner != OWN_NONE);
      if (owner != prev_owner && owner != OWN_NONE) begin
        chk("idle_gap", prev_owner, OWN_NONE);
        grant_log.push_back(owner);
      end
      case (owner)
        OWN_NONE: begin
          chk("idle_mem_req", mem_req, '0);
          chk("idle_ifu_rsp", ifu_rsp, '0);
          chk("idle_lsu_rsp", lsu_rsp, '0);
        end
        OWN_IFU_RD: begin
          chk("ifu_own_lsu_rsp", lsu_rsp, '0);
          chk("ifu_no_b_awready", {ifu_rsp.bvalid, ifu_rsp.awready}, 2'b00);
          chk("ifu_no_wr_fwd", {mem_req.awvalid, mem_req.wvalid}, 2'b00);
        end
        default: chk("lsu_own_ifu_rsp", ifu_rsp, '0);
      endcase
      prev_owner = owner;
    end
  end

  task automatic do_read(input bit is_lsu, input logic [31:0] addr, input logic [31:0] exp,
                         input logic [1:0] exp_own);
    axi_rsp_t    r;
    logic [31:0] e;
    bit          done;
    int          cyc;
    if (is_lsu) begin
      lsu_q.push_back(exp);
      lsu_req.arvalid = 1'b1; lsu_req.araddr = addr; lsu_req.rready = 1'b1;
    end else begin
      ifu_q.push_back(exp);
      ifu_req.arvalid = 1'b1; ifu_req.araddr = addr; ifu_req.rready = 1'b1;
    end
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < BUDGET) begin
      r = is_lsu ? lsu_rsp : ifu_rsp;
      @(negedge clk);
      cyc++;
      if (cyc == 1 && exp_own != OWN_NONE) chk("rd_grant_owner", owner, exp_own);
      if (r.arready) done = 1'b1;
    end
    chk("ar_handshake", done, 1'b1);
    if (is_lsu) lsu_req.arvalid = 1'b0; else ifu_req.arvalid = 1'b0;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < BUDGET) begin
      r = is_lsu ? lsu_rsp : ifu_rsp;
      if (r.rvalid) done = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    chk("r_handshake", done, 1'b1);
    if (done) begin
      e = is_lsu ? lsu_q.pop_front() : ifu_q.pop_front();
      chk(is_lsu ? "lsu_rdata" : "ifu_rdata", r.rdata, e);
      chk("rresp_okay", r.rresp, RESP_OKAY);
      @(negedge clk);
      chk("rd_release_owner", owner, OWN_NONE);
    end
    if (is_lsu) lsu_req = '0; else ifu_req = '0;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                          input int lead, input logic [1:0] exp_own);
    int  aw_start, w_start, cyc;
    bit  aw_hs, w_hs, b_hs, done;
    wr_q.push_back('{a: addr, d: data, s: strb});
    aw_start = (lead < 0) ? 0 : lead;
    w_start  = (lead < 0) ? -lead : 0;
    lsu_req.bready = 1'b1;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < BUDGET) begin
      if (cyc == aw_start) begin lsu_req.awvalid = 1'b1; lsu_req.awaddr = addr; end
      if (cyc == w_start) begin lsu_req.wvalid = 1'b1; lsu_req.wdata = data; lsu_req.wstrb = strb; end
      aw_hs = lsu_req.awvalid && lsu_rsp.awready;
      w_hs  = lsu_req.wvalid && lsu_rsp.wready;
      b_hs  = lsu_rsp.bvalid;
      if (b_hs) chk("bresp_okay", lsu_rsp.bresp, RESP_OKAY);
      @(negedge clk);
      cyc++;
      if (cyc == 1 && exp_own != OWN_NONE) chk("wr_grant_owner", owner, exp_own);
      if (aw_hs) lsu_req.awvalid = 1'b0;
      if (w_hs) lsu_req.wvalid = 1'b0;
      if (b_hs) done = 1'b1;
    end
    chk("b_handshake", done, 1'b1);
    chk("wr_release_owner", owner, OWN_NONE);
    lsu_req = '0;
  endtask

  typedef struct {
    bit          is_wr;
    bit          is_lsu;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  strb;
    int          lead;
    logic [1:0]  exp_owner;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 0, 32'h8000_0000, 32'h0000_0413, 8'h00,  0, OWN_IFU_RD};
    tbl[1] = '{1, 1, 32'h8000_2000, 32'hDEAD_BEEF, 8'h0F,  2, OWN_LSU_WR};
    tbl[2] = '{0, 1, 32'h8000_2000, 32'hDEAD_BEEF, 8'h00,  0, OWN_LSU_RD};
    tbl[3] = '{1, 1, 32'h8000_2000, 32'h0000_CAFE, 8'h03,  0, OWN_LSU_WR};
    tbl[4] = '{0, 0, 32'h8000_2000, 32'hDEAD_CAFE, 8'h00,  0, OWN_IFU_RD};
    tbl[5] = '{1, 1, 32'h8000_3000, 32'h1234_5678, 8'h0F, -2, OWN_LSU_WR};
    tbl[6] = '{0, 1, 32'h8000_3000, 32'h1234_5678, 8'h00,  0, OWN_LSU_RD};
    tbl[7] = '{0, 0, 32'h8000_1000, 32'hDA5A_1000, 8'h00,  0, OWN_IFU_RD};

    hold_r  = 1'b0;
    ifu_req = '0;
    lsu_req = '0;
    rst     = 1'b1;
    ifu_req.arvalid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_owner", owner, OWN_NONE);
      chk("rst_busy", busy, 1'b0);
      chk("rst_mem_req", mem_req, '0);
      chk("rst_ifu_rsp", ifu_rsp, '0);
      chk("rst_lsu_rsp", lsu_rsp, '0);
    end
    ifu_req = '0;
    rst     = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].is_wr) do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, tbl[i].lead, tbl[i].exp_owner);
      else do_read(tbl[i].is_lsu, tbl[i].addr, tbl[i].data, tbl[i].exp_owner);
      @(negedge clk);
    end

    ifu_req.awvalid = 1'b1;
    ifu_req.wvalid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ifu_aw_ignored_owner", owner, OWN_NONE);
    end
    ifu_req = '0;
    @(negedge clk);

    // Same-cycle conflict: LSU read wins, IFU follows after an idle cycle
    grant_log.delete();
    fork
      do_read(1'b1, 32'h8000_1000, 32'hDA5A_1000, OWN_LSU_RD);
      do_read(1'b0, 32'h8000_0000, 32'h0000_0413, OWN_NONE);
    join
    chk("conflict_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("conflict_first", grant_log[0], OWN_LSU_RD);
      chk("conflict_second", grant_log[1], OWN_IFU_RD);
    end
    @(negedge clk);

    // LSU write arriving mid IFU grant must wait
    grant_log.delete();
    fork
      do_read(1'b0, 32'h8000_3000, 32'h1234_5678, OWN_IFU_RD);
      begin
        @(negedge clk);
        do_write(32'h8000_4000, 32'hAABB_CCDD, 8'h0F, 0, OWN_NONE);
      end
    join
    chk("nopreempt_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("nopreempt_first", grant_log[0], OWN_IFU_RD);
      chk("nopreempt_second", grant_log[1], OWN_LSU_WR);
    end
    @(negedge clk);

    // Reset while LSU read waits for rvalid
    hold_r = 1'b1;
    lsu_req.arvalid = 1'b1;
    lsu_req.araddr  = 32'h8000_1000;
    lsu_req.rready  = 1'b1;
    @(negedge clk);
    chk("midrst_grant", owner, OWN_LSU_RD);
    @(negedge clk);
    lsu_req.arvalid = 1'b0;
    chk("midrst_stalled", owner, OWN_LSU_RD);
    rst = 1'b1;
    #1;
    chk("midrst_owner", owner, OWN_NONE);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_mem_req", mem_req, '0);
    chk("midrst_lsu_rsp", lsu_rsp, '0);
    lsu_req = '0;
    hold_r  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_read(1'b0, 32'h8000_0000, 32'h0000_0413, OWN_IFU_RD);
    @(negedge clk);

`ifdef ARB_TIMEOUT_EN
    begin
      int cyc, g;
      hold_r = 1'b1;
      ifu_req.arvalid = 1'b1;
      ifu_req.araddr  = 32'h8000_0000;
      ifu_req.rready  = 1'b0;
      cyc = 0;
      g   = 0;
      while (!ifu_rsp.rvalid && cyc < 100) begin
        @(negedge clk);
        cyc++;
        if (cyc == 2) ifu_req.arvalid = 1'b0;
        if (owner == OWN_IFU_RD && !ifu_rsp.rvalid) g++;
      end
      chk("to_grant_cycles", g, TO);
      chk("to_rvalid", ifu_rsp.rvalid, 1'b1);
      chk("to_rresp", ifu_rsp.rresp, RESP_DECERR);
      chk("to_rdata", ifu_rsp.rdata, 32'h0);
      chk("to_mem_valids", {mem_req.arvalid, mem_req.awvalid, mem_req.wvalid}, 3'b000);
      repeat (2) begin
        @(negedge clk);
        chk("to_rvalid_held", ifu_rsp.rvalid, 1'b1);
      end
      ifu_req.rready = 1'b1;
      @(negedge clk);
      chk("to_release_owner", owner, OWN_NONE);
      ifu_req = '0;
      hold_r  = 1'b0;
      @(negedge clk);
    end
`endif

    chk("ifu_scoreboard_empty", ifu_q.size(), 0);
    chk("lsu_scoreboard_empty", lsu_q.size(), 0);
    chk("wr_scoreboard_empty", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single AXI-lite memory slave (SRAM model) between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write).
- Grants one whole transaction at a time: address, data and response phases complete before the grant is released.
- Sits between the IFU/LSU bus ports and the SRAM; request and response signals pass through combinationally while a grant is held.

Parameters:
- TIMEOUT_CYCLES, 1024: grant watchdog limit in cycles. Used only when ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- ifu_req  in  axi_req_t  IFU request bundle (only AR/R fields used; AW/W/B fields ignored)
- ifu_rsp  out  axi_rsp_t  IFU response bundle
- lsu_req  in  axi_req_t  LSU request bundle
- lsu_rsp  out  axi_rsp_t  LSU response bundle
- mem_req  out  axi_req_t  request bundle to the SRAM
- mem_rsp  in  axi_rsp_t  response bundle from the SRAM
- owner  out  2  current grant: 00 none, 01 IFU read, 10 LSU read, 11 LSU write
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state goes to IDLE; owner=00, busy=0.
  - mem_req, ifu_rsp and lsu_rsp are all-zero.
  - Any in-flight SRAM transaction is abandoned; the SRAM shares rst.
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR, plus ERR_RSP when ARB_TIMEOUT_EN is defined.
- IDLE:
  - All mem_req valids and all master-side readies/valids are 0.
  - Priority when several requests are present in the same cycle: lsu_req.awvalid|wvalid first, then lsu_req.arvalid, then ifu_req.arvalid.
  - The chosen state is registered, so the grant takes effect the next cycle (1-cycle arbitration latency).
  - A request withdrawn before the grant state is entered starts no transaction.
- Grant states:
  - mem_req equals the granted master's req bundle; all other fields of mem_req are 0.
  - The granted master's rsp bundle equals mem_rsp; the other master's rsp bundle is all-zero.
  - Masters hold valid until ready, per AXI rules.
- LSU_WR: AW and W pass through independently, in either order.
- Release:
  - IFU_RD and LSU_RD return to IDLE on the cycle after rvalid&rready.
  - LSU_WR returns to IDLE on the cycle after bvalid&bready.
  - At least one IDLE cycle always separates two transactions. There is no back-to-back chaining.
- A higher-priority request arriving mid-grant never preempts the current owner.
- IFU AW/W valids are ignored. IFU bvalid and awready are always 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to any grant state and increments each grant cycle.
  - When it reaches TIMEOUT_CYCLES without completion, the FSM enters ERR_RSP and all mem_req valids drop to 0.
  - In ERR_RSP the owning master receives rvalid=1, rdata=0, rresp=2'b11 for a read owner, or bvalid=1, bresp=2'b11 for a write owner.
  - The response is held until the master's rready/bready, then the FSM returns to IDLE.
- Undefined: no counter and no ERR_RSP state; a grant is held indefinitely.

Decomposition:
- Package mem_bus_pkg:
  - ADDR_W=32, DATA_W=32, STRB_W=8.
  - RESP_OKAY=2'b00, RESP_DECERR=2'b11.
  - Packed axi_req_t {arvalid, araddr[ADDR_W], rready, awvalid, awaddr[ADDR_W], wvalid, wdata[DATA_W], wstrb[STRB_W], bready}.
  - Packed axi_rsp_t {arready, rvalid, rdata[DATA_W], rresp[2], awready, wready, bvalid, bresp[2]}.
  - arb_state_e enum and owner encodings.
- Sub-module: none. The FSM and muxes stay in one module.

Test Plan:
- IFU read: ifu arvalid, araddr=0x80000000; SRAM returns rdata=0x00000413 -> owner=01 from the next cycle; ifu_rsp.rdata=0x00000413; IDLE one cycle after rvalid&rready; lsu_rsp all-zero throughout.
- Same-cycle conflict: ifu arvalid and lsu arvalid (0x80001000) in the same cycle -> owner=10 first; IFU is granted only after the LSU R handshake plus one IDLE cycle.
- LSU write: awaddr=0x80002000, wdata=0xDEADBEEF, wstrb=8'h0F, with W valid two cycles before AW -> SRAM sees both unchanged; release on bvalid&bready; owner=11 only during the write.
- No preemption: LSU write requested while IFU_RD is active -> IFU completes; LSU_WR begins one IDLE cycle later.
- Reset mid-grant: assert rst in LSU_RD before rvalid -> same-cycle owner=00, busy=0, mem_req zero; after reset deasserts, a new IFU read completes normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, SRAM never asserts rvalid on an IFU read -> after 16 grant cycles, ifu_rsp.rvalid=1, rresp=2'b11, rdata=0; IDLE after rready.
